beep_pattern_module: RTL
========================

Name: beep_pattern_module

Overview:
Programmable buzzer pattern generator: on a start request, emits pulse_cnt beeps, each on_ms long, separated by off_ms gaps, then issues a one-cycle done pulse. It generalises the fixed S/O-code beeper with run-time durations and count, parametrised clock and timebase, abort, busy status and selectable pin polarity. It sits between control logic and the buzzer pin.

Parameters:
CLK_FREQ_HZ, 50_000_000, input clock frequency.
TICK_HZ, 1000, timebase rate; TICK_DIV = CLK_FREQ_HZ/TICK_HZ cycles per time unit (1 ms at defaults); must divide exactly and be >= 2.
TIME_W, 12, width of on_ms/off_ms (max 4095 units).
CNT_W, 4, width of pulse_cnt (max 15 beeps).
PIN_ACTIVE_LOW, 1, 1: beep_pin driven low when sounding; 0: driven high.
TONE_HALF, 12500, tone half-period in cycles (2 kHz at 50 MHz); used only with BEEP_TONE_EN.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RST  input  1  synchronous reset, active-high.
start  input  1  request; sampled only in IDLE.
abort  input  1  cancel any pattern in progress.
on_ms  input  TIME_W  beep duration in ticks; latched on accepted start.
off_ms  input  TIME_W  gap duration in ticks; latched on accepted start.
pulse_cnt  input  CNT_W  number of beeps; latched on accepted start.
busy  output  1  high while a pattern is in progress (ON, OFF, DONE).
done  output  1  one-cycle pulse on normal completion.
beep_pin  output  1  buzzer drive, polarity per PIN_ACTIVE_LOW.

Behaviour:
- Reset (RST=1 at an edge): state IDLE, all counters 0, busy=0, done=0, beep_pin inactive (PIN_ACTIVE_LOW ? 1 : 0). Applies mid-pattern; no done.
- All outputs registered. States: IDLE, ON, OFF, DONE.
- IDLE: start=1 and abort=0 -> latch on_ms, off_ms, pulse_cnt; go to ON if pulse_cnt != 0, else to DONE directly (no beep).
- Zero duration: on_ms=0 or off_ms=0 treated as 1 tick.
- Phase timing: prescaler (width clog2(TICK_DIV)) and tick counter (TIME_W) cleared on every phase entry; a phase of D ticks lasts exactly D*TICK_DIV cycles.
- ON: beep_pin active; at phase end decrement remaining count; remaining becomes 0 -> DONE, else -> OFF. No trailing gap after the last beep.
- OFF: beep_pin inactive; at phase end -> ON.
- DONE: exactly one cycle; done=1, beep_pin inactive; -> IDLE.
- busy=1 in ON, OFF, DONE; 0 in IDLE.
- Latency: start sampled at edge 0 -> busy=1 and beep_pin active from edge 0 output (cycle 1).
- start while busy: ignored; latched parameters unchanged; input changes mid-pattern have no effect.
- abort=1 in ON/OFF/DONE -> IDLE next edge, beep_pin inactive, busy=0, done not asserted. abort beats start in the same cycle. abort in IDLE: no effect.
- Back-to-back: start in the cycle after DONE (state IDLE) is accepted.

Optional Feature:
Macro BEEP_TONE_EN. Defined: during ON, beep_pin toggles every TONE_HALF cycles, starting active at phase entry (drives a passive buzzer); tone divider reset at each ON entry; pin inactive in all other states. Not defined: beep_pin held constant active throughout ON (active buzzer); TONE_HALF unused, no tone divider logic.

Test Plan:
(Bench uses CLK_FREQ_HZ=1000, TICK_HZ=100 -> TICK_DIV=10, PIN_ACTIVE_LOW=1, cycles counted from the start-sampling edge.)
Reset held 3 cycles, then released -> beep_pin=1, busy=0, done=0; no activity without start.
start with on_ms=3, off_ms=2, pulse_cnt=2 -> beep_pin=0 cycles 1-30, 1 cycles 31-50, 0 cycles 51-80; done=1 only in cycle 81; busy=1 cycles 1-81, 0 from 82.
start with pulse_cnt=0 -> done=1 in cycle 1, busy=1 only in cycle 1, beep_pin stays 1.
start with on_ms=5, off_ms=1, pulse_cnt=3, abort at cycle 15 -> beep_pin=1 and busy=0 from cycle 16, no done pulse; new start at cycle 20 accepted, busy=1 at 21.
start with on_ms=0, off_ms=0, pulse_cnt=2; second start with on_ms=9 at cycle 5 -> ignored; beep_pin=0 cycles 1-10 and 21-30, done in 31.
BEEP_TONE_EN defined, TONE_HALF=2, on_ms=1, pulse_cnt=1 -> beep_pin 0,0,1,1,0,0,1,1,0,0 over cycles 1-10; done in cycle 11, beep_pin=1.

Source files
------------

// File: rtl/beep_pattern_module.sv
// beep_pattern_module
//   Programmable buzzer pattern generator. When start is accepted, it emits
//   pulse_cnt beeps. Each beep lasts on_ms ticks and the beeps are separated
//   by off_ms ticks of silence. After the last beep it gives a one-cycle done
//   pulse. A duration of zero is treated as one tick. A count of zero goes
//   straight to the done pulse. One tick is CLK_FREQ_HZ/TICK_HZ clock cycles.
//
//   Ports:
//     CLK        system clock, rising edge
//     RST        synchronous reset, active-high
//     start      pattern request, sampled only while idle
//     abort      cancels a pattern in progress, with no done pulse
//     on_ms      beep duration in ticks, latched on an accepted start
//     off_ms     gap duration in ticks, latched on an accepted start
//     pulse_cnt  number of beeps, latched on an accepted start
//     busy       high while a pattern is in progress
//     done       one-cycle pulse on normal completion
//     beep_pin   buzzer drive; active level set by PIN_ACTIVE_LOW
//
//   Optional macro BEEP_TONE_EN: while a beep sounds, beep_pin toggles every
//   TONE_HALF cycles to drive a passive buzzer. Without the macro, beep_pin
//   stays at the active level for the whole beep.
module beep_pattern_module #(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned TICK_HZ        = 1000,
    parameter int unsigned TIME_W         = 12,
    parameter int unsigned CNT_W          = 4,
    parameter bit          PIN_ACTIVE_LOW = 1'b1,
    parameter int unsigned TONE_HALF      = 12500
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [TIME_W-1:0] on_ms,
    input  logic [TIME_W-1:0] off_ms,
    input  logic [CNT_W-1:0]  pulse_cnt,
    output logic              busy,
    output logic              done,
    output logic              beep_pin
);

    localparam int unsigned      TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned      PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic             PIN_ON   = PIN_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic             PIN_OFF  = ~PIN_ON;

    if ((CLK_FREQ_HZ % TICK_HZ) != 0 || TICK_DIV < 2 || TONE_HALF == 0) begin : g_cfg_check
        $error("beep_pattern_module: invalid timebase or tone configuration");
    end

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [TIME_W-1:0]   tick_q, tick_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [TIME_W-1:0]   on_q, on_d;
    logic [TIME_W-1:0]   off_q, off_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                beep_pin_q, beep_pin_d;
    logic [TIME_W-1:0]   phase_len;
    logic                phase_end;

`ifdef BEEP_TONE_EN
    localparam int unsigned      TONE_W    = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tone_ph_q, tone_ph_d;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            tick_q     <= '0;
            rem_q      <= '0;
            on_q       <= '0;
            off_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            beep_pin_q <= PIN_OFF;
`ifdef BEEP_TONE_EN
            tone_cnt_q <= '0;
            tone_ph_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            rem_q      <= rem_d;
            on_q       <= on_d;
            off_q      <= off_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            beep_pin_q <= beep_pin_d;
`ifdef BEEP_TONE_EN
            tone_cnt_q <= tone_cnt_d;
            tone_ph_q  <= tone_ph_d;
`endif
        end
    end

    // The latched durations are never zero, so the tick count that ends
    // the phase is always phase_len-1.
    assign phase_len = (state_q == S_ON) ? on_q : off_q;
    assign phase_end = (pre_q == PRE_LAST) && (tick_q == phase_len - TIME_W'(1));

    // Next-state logic, phase timer and latched parameters
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tick_d  = tick_q;
        rem_d   = rem_q;
        on_d    = on_q;
        off_d   = off_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    on_d    = (on_ms  == '0) ? TIME_W'(1) : on_ms;
                    off_d   = (off_ms == '0) ? TIME_W'(1) : off_ms;
                    rem_d   = pulse_cnt;
                    pre_d   = '0;
                    tick_d  = '0;
                    state_d = (pulse_cnt != '0) ? S_ON : S_DONE;
                end
            end
            S_ON, S_OFF: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    tick_d  = '0;
                end else if (phase_end) begin
                    pre_d  = '0;
                    tick_d = '0;
                    if (state_q == S_ON) begin
                        rem_d   = rem_q - CNT_W'(1);
                        state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_OFF;
                    end else begin
                        state_d = S_ON;
                    end
                end else if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    tick_d = tick_q + TIME_W'(1);
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    // That way each output changes on the same edge as the state.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
`ifdef BEEP_TONE_EN
        // Tone divider restarts at every ON entry, so each beep starts active
        tone_cnt_d = '0;
        tone_ph_d  = 1'b0;
        if (state_q == S_ON && state_d == S_ON) begin
            if (tone_cnt_q == TONE_LAST) begin
                tone_ph_d = ~tone_ph_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TONE_W'(1);
                tone_ph_d  = tone_ph_q;
            end
        end
        beep_pin_d = (state_d == S_ON && !tone_ph_d) ? PIN_ON : PIN_OFF;
`else
        beep_pin_d = (state_d == S_ON) ? PIN_ON : PIN_OFF;
`endif
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign beep_pin = beep_pin_q;

endmodule
